// File: rtl/aes_pkg.sv
// Shared AES datapath types and helpers for the round stages.
//   state_t       : 128-bit AES state, row-major (each 32-bit word is a row)
//   col_t         : one 32-bit column, row 0 in the top byte
//   mcols_state_t : MixColumns sequencer FSM states
//   gf_xtime      : multiply by x (0x02) in GF(2^8) modulo 0x11B
//   get_col       : extract column c from a row-major state
//   put_col       : replace column c in a row-major state
package aes_pkg;

  typedef logic [127:0] state_t;
  typedef logic [31:0]  col_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mcols_state_t;

  function automatic logic [7:0] gf_xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // byte(r,c) lives at s[127-32r-8c -: 8]; the column word packs rows 0..3
  // from its most significant byte down.
  function automatic col_t get_col(input state_t s, input logic [1:0] c);
    col_t col;
    col = '0;
    for (int r = 0; r < 4; r++) begin
      col[31-8*r -: 8] = s[127-32*r-8*int'(c) -: 8];
    end
    return col;
  endfunction

  function automatic state_t put_col(input state_t s, input logic [1:0] c,
                                     input col_t col);
    state_t o;
    o = s;
    for (int r = 0; r < 4; r++) begin
      o[127-32*r-8*int'(c) -: 8] = col[31-8*r -: 8];
    end
    return o;
  endfunction

endpackage

// File: rtl/mcol_word.sv
// Single-column AES MixColumns, purely combinational.
//   col_in  : input column, row 0 in bits [31:24]
//   inv     : 0 = forward MixColumns, 1 = inverse MixColumns
//   col_out : mixed column, same layout as col_in
// All constant products are built from xtime chains (x2, x4, x8).
module mcol_word
  import aes_pkg::*;
(
  input  col_t col_in,
  input  logic inv,
  output col_t col_out
);

  logic [7:0] s  [4];
  logic [7:0] x2 [4];
  logic [7:0] x4 [4];
  logic [7:0] x8 [4];
  logic [7:0] m3 [4];
  logic [7:0] m9 [4];
  logic [7:0] mb [4];
  logic [7:0] md [4];
  logic [7:0] me [4];

  always_comb begin
    s  = '{default: '0};
    x2 = '{default: '0};
    x4 = '{default: '0};
    x8 = '{default: '0};
    m3 = '{default: '0};
    m9 = '{default: '0};
    mb = '{default: '0};
    md = '{default: '0};
    me = '{default: '0};
    for (int i = 0; i < 4; i++) begin
      s[i]  = col_in[31-8*i -: 8];
      x2[i] = gf_xtime(s[i]);
      x4[i] = gf_xtime(x2[i]);
      x8[i] = gf_xtime(x4[i]);
      m3[i] = x2[i] ^ s[i];
      m9[i] = x8[i] ^ s[i];
      mb[i] = x8[i] ^ x2[i] ^ s[i];
      md[i] = x8[i] ^ x4[i] ^ s[i];
      me[i] = x8[i] ^ x4[i] ^ x2[i];
    end
  end

  // Both matrices are circulant: output row r uses coefficients rotated by r.
  always_comb begin
    col_out = '0;
    for (int r = 0; r < 4; r++) begin
      if (inv) begin
        col_out[31-8*r -: 8] = me[r] ^ mb[(r+1)%4] ^ md[(r+2)%4] ^ m9[(r+3)%4];
      end else begin
        col_out[31-8*r -: 8] = x2[r] ^ m3[(r+1)%4] ^ s[(r+2)%4] ^ s[(r+3)%4];
      end
    end
  end

endmodule

// File: rtl/mcols_seq.sv
// Sequential AES MixColumns stage, placed after ShiftRows in the round.
//   clk            : system clock, rising edge
//   rst            : asynchronous active-high reset
//   olddata        : row-major state from ShiftRows
//   mcols_enable   : start request, sampled only in IDLE
//   inv_mode       : 0 = forward, 1 = inverse; captured on the start edge
//   mcols_busy     : high while columns are being mixed
//   mcols_finished : one-cycle pulse after the last column is written
//   newdata        : working register; final only once finished has pulsed
//
// Handshake: a start is accepted on any edge where the FSM is IDLE and
// mcols_enable is high. Busy rises from that edge and stays high for
// 4/COLS_PER_CYCLE cycles; finished then pulses for exactly one cycle while
// busy is low, and the next edge returns to IDLE. Enables seen in BUSY or
// DONE are dropped, so holding enable high restarts every N+2 cycles.
module mcols_seq
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
)(
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] olddata,
  input  logic         mcols_enable,
  input  logic         inv_mode,
  output logic         mcols_busy,
  output logic         mcols_finished,
  output logic [127:0] newdata
);

  // Column counter step; for 4 columns/cycle this wraps to 0, which is
  // harmless because only one step is ever taken.
  localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);

  mcols_state_t state_q;
  mcols_state_t state_d;
  logic [1:0]   cnt_q;
  logic         inv_q;
  state_t       work_q;
  state_t       work_d;
  logic         last_step;

  logic [1:0] col_idx [COLS_PER_CYCLE];
  col_t       col_in  [COLS_PER_CYCLE];
  col_t       col_out [COLS_PER_CYCLE];

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
    assign col_idx[g] = cnt_q + 2'(g);
    assign col_in[g]  = get_col(work_q, col_idx[g]);

    mcol_word u_mcol_word (
      .col_in  (col_in[g]),
      .inv     (inv_q),
      .col_out (col_out[g])
    );
  end

  // This step writes column 3 when the slice counter..counter+C-1 reaches it.
  assign last_step = (int'(cnt_q) + COLS_PER_CYCLE) >= 4;

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mcols_enable) state_d = BUSY;
      BUSY:    if (last_step)    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs, decoded straight from the state register so they are
  // glitch-free and change only at clock edges.
  always_comb begin
    mcols_busy     = (state_q == BUSY);
    mcols_finished = (state_q == DONE);
  end

  // Merge this cycle's mixed columns into the working register.
  always_comb begin
    work_d = work_q;
    for (int g = 0; g < COLS_PER_CYCLE; g++) begin
      work_d = put_col(work_d, col_idx[g], col_out[g]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      inv_q  <= 1'b0;
      work_q <= '0;
    end else if (state_q == IDLE && mcols_enable) begin
      cnt_q  <= '0;
      inv_q  <= inv_mode;
      work_q <= olddata;
    end else if (state_q == BUSY) begin
      cnt_q  <= cnt_q + CNT_STEP;
      work_q <= work_d;
    end
  end

  assign newdata = work_q;

endmodule

// File: tb/tb_mcols_seq.sv
// Bench for mcols_seq: three instances (1, 2 and 4 columns per cycle) share
// one stimulus stream and are compared every cycle against a spec-level model
// (GF(2^8) shift-and-add multiply, matrix-times-column, start/finish timing
// derived from edge counts).
module tb_mcols_seq;

  logic         clk;
  logic         rst;
  logic [127:0] olddata;
  logic         mcols_enable;
  logic         inv_mode;
  logic [2:0]   busy;
  logic [2:0]   fin;
  logic [127:0] nd [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mcols_seq #(.COLS_PER_CYCLE(1 << g)) u_dut (
      .clk            (clk),
      .rst            (rst),
      .olddata        (olddata),
      .mcols_enable   (mcols_enable),
      .inv_mode       (inv_mode),
      .mcols_busy     (busy[g]),
      .mcols_finished (fin[g]),
      .newdata        (nd[g])
    );
  end

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [127:0] exp_q [$];

  int           ecount = 0;
  bit           act     [3];
  int           e0      [3];
  int           free_at [3];
  logic [127:0] orig_s  [3];
  logic [127:0] res_s   [3];
  logic [127:0] exp_nd  [3];
  int           fin_edge[3];
  int           last_fin[3];
  int           fin_cnt [3];
  logic [2:0]   fin_seen;
  bit           b2b;
  int           start_e;

  localparam logic [127:0] KAT_A = 128'hdbf201d4_130a01bf_5322015d_455c0130;
  localparam logic [127:0] KAT_B = 128'h8e9f0104_4ddc0166_a1580181_bc9d01e5;

  task automatic chk(input string name, input logic [127:0] got,
                     input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] mix_ref(input logic [127:0] s, input bit inv);
    logic [7:0]   base [4];
    logic [7:0]   acc;
    logic [127:0] r;
    if (inv) base = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     base = '{8'h02, 8'h03, 8'h01, 8'h01};
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) begin
          acc = acc ^ gf_mul(base[(j - row) & 3], s[127-32*j-8*c -: 8]);
        end
        r[127-32*row-8*c -: 8] = acc;
      end
    end
    return r;
  endfunction

  // Columns below nc come from res, the rest from orig.
  function automatic logic [127:0] merge(input logic [127:0] orig,
                                         input logic [127:0] res, input int nc);
    logic [127:0] o;
    o = orig;
    for (int c = 0; c < nc && c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-32*r-8*c -: 8] = res[127-32*r-8*c -: 8];
      end
    end
    return o;
  endfunction

  // Model update at every rising edge from the inputs as they were sampled.
  initial begin
    for (int k = 0; k < 3; k++) begin
      act[k] = 1'b0; e0[k] = 0; free_at[k] = 0;
      orig_s[k] = '0; res_s[k] = '0; exp_nd[k] = '0;
    end
    forever begin
      @(posedge clk);
      ecount++;
      for (int k = 0; k < 3; k++) begin
        if (rst) begin
          act[k]     = 1'b0;
          exp_nd[k]  = '0;
          free_at[k] = ecount + 1;
        end else if (ecount >= free_at[k] && mcols_enable) begin
          act[k]     = 1'b1;
          e0[k]      = ecount;
          orig_s[k]  = olddata;
          res_s[k]   = mix_ref(olddata, inv_mode);
          exp_nd[k]  = olddata;
          free_at[k] = ecount + (4 >> k) + 2;
        end else if (act[k] && (ecount - e0[k]) <= (4 >> k)) begin
          exp_nd[k] = merge(orig_s[k], res_s[k], (ecount - e0[k]) * (1 << k));
        end
      end
    end
  end

  // Compare process: every falling edge, all three instances.
  initial begin
    int d;
    logic eb;
    logic ef;
    for (int k = 0; k < 3; k++) begin
      fin_edge[k] = -1; last_fin[k] = -1; fin_cnt[k] = 0;
    end
    fin_seen = '0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (rst) begin
          eb = 1'b0; ef = 1'b0;
        end else begin
          d  = ecount - e0[k];
          eb = act[k] && d >= 0 && d < (4 >> k);
          ef = act[k] && d == (4 >> k);
        end
        chk($sformatf("busy%0d", k), busy[k], eb);
        chk($sformatf("finished%0d", k), fin[k], ef);
        chk($sformatf("newdata%0d", k), nd[k], rst ? 128'h0 : exp_nd[k]);
        if (fin[k]) begin
          if (b2b && last_fin[k] >= 0)
            chk($sformatf("b2b_spacing%0d", k), ecount - last_fin[k], (4 >> k) + 2);
          last_fin[k] = ecount;
          fin_edge[k] = ecount;
          fin_seen[k] = 1'b1;
          fin_cnt[k]++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_all_fin(input string name);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      #1;
      if (fin_seen == 3'b111) break;
    end
    chk(name, fin_seen, 3'b111);
  endtask

  // One operation: start, scramble inputs afterwards, wait, check result and latency.
  task automatic run_op(input string name, input logic [127:0] d, input bit inv,
                        input logic [127:0] want);
    logic [127:0] e;
    exp_q.push_back(want);
    step();
    olddata = d; inv_mode = inv; mcols_enable = 1'b1;
    start_e = ecount + 1;
    fin_seen = '0;
    step();
    mcols_enable = 1'b0;
    olddata = {$urandom, $urandom, $urandom, $urandom};
    inv_mode = 1'($urandom_range(0, 1));
    wait_all_fin({name, "_done"});
    e = exp_q.pop_front();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s_result%0d", name, k), nd[k], e);
      chk($sformatf("%s_latency%0d", name, k), fin_edge[k] - start_e + 1, (4 >> k) + 1);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [127:0] x;
    logic [127:0] y;
    bit m;
    rst = 1'b1; mcols_enable = 1'b0; olddata = '0; inv_mode = 1'b0; b2b = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset_busy%0d", k), busy[k], 1'b0);
      chk($sformatf("reset_fin%0d", k), fin[k], 1'b0);
      chk($sformatf("reset_newdata%0d", k), nd[k], 128'h0);
    end

    // Pin the model to hand-computed values.
    chk("pin_gf_mul", gf_mul(8'h57, 8'h83), 8'hc1);
    chk("pin_fwd", mix_ref(KAT_A, 1'b0), KAT_B);
    chk("pin_inv", mix_ref(KAT_B, 1'b1), KAT_A);

    // Known answers.
    run_op("kat_fwd", KAT_A, 1'b0, KAT_B);
    run_op("kat_inv", KAT_B, 1'b1, KAT_A);
    run_op("c6_fwd", {16{8'hc6}}, 1'b0, {16{8'hc6}});
    run_op("c6_inv", {16{8'hc6}}, 1'b1, {16{8'hc6}});

    // Enable pulse with different data while busy is ignored.
    for (int k = 0; k < 3; k++) fin_cnt[k] = 0;
    step();
    olddata = KAT_A; inv_mode = 1'b0; mcols_enable = 1'b1; fin_seen = '0;
    step();                                        // E0 taken
    mcols_enable = 1'b0;
    step();                                        // after E1
    olddata = KAT_B; inv_mode = 1'b1; mcols_enable = 1'b1;
    step();                                        // after E2
    mcols_enable = 1'b0;
    wait_all_fin("ignore_done");
    repeat (8) step();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("ignore_result%0d", k), nd[k], KAT_B);
      chk($sformatf("ignore_fincount%0d", k), fin_cnt[k], 1);
    end

    // Reset in the middle of an operation.
    for (int k = 0; k < 3; k++) fin_cnt[k] = 0;
    step();
    olddata = KAT_A; inv_mode = 1'b0; mcols_enable = 1'b1;
    step();                                        // E0 taken
    mcols_enable = 1'b0;
    step();                                        // after E1
    step();                                        // after E2
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("midreset_newdata", nd[0], 128'h0);
    chk("midreset_busy", busy[0], 1'b0);
    step();
    rst = 1'b0;
    repeat (8) step();
    chk("midreset_no_finish", fin_cnt[0], 0);
    run_op("after_reset", KAT_A, 1'b0, KAT_B);

    // Back-to-back with enable held high; the model checks each result.
    for (int k = 0; k < 3; k++) begin
      fin_cnt[k] = 0; last_fin[k] = -1;
    end
    b2b = 1'b1;
    step();
    mcols_enable = 1'b1;
    for (int i = 0; i < 18; i++) begin
      olddata = {$urandom, $urandom, $urandom, $urandom};
      inv_mode = 1'($urandom_range(0, 1));
      step();
    end
    mcols_enable = 1'b0;
    repeat (8) step();
    b2b = 1'b0;
    chk("b2b_count0", fin_cnt[0], 3);

    // Randomised round trips in both orders.
    for (int i = 0; i < 1000; i++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      m = 1'(i % 2);
      run_op("rnd_first", x, m, mix_ref(x, m));
      y = nd[0];
      run_op("rnd_back", y, !m, x);
    end

    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
